// File: rtl/cbus_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : cbus_rr_arbiter (plus cbus_pkg type package)
// Purpose  : Round-robin, transaction-locked arbiter that shares one external
//            cbus master port between NUM_INPUTS requesters (port 0 = ICache,
//            port 1 = DCache at the top level). One requester owns the bus
//            from grant until the ready&&last response beat.
// Ports    : clk        - system clock
//            resetn     - synchronous active-low reset
//            ireqs[i]   - per-requester cbus request
//            iresps[i]  - per-requester cbus response (only the owner sees oresp)
//            oreq       - request forwarded to the external cbus
//            oresp      - response from the external cbus
//            busy       - high while a transaction is owned
//            grant_idx  - index of the current or most recent owner
// Revision : 1.0 - initial release
//==============================================================================

package cbus_pkg;
   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      logic [3:0]  len;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;
endpackage

module cbus_rr_arbiter
   import cbus_pkg::*;
#(
   parameter int NUM_INPUTS = 2,
   parameter int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  cbus_req_t        ireqs  [NUM_INPUTS],
   output cbus_resp_t       iresps [NUM_INPUTS],
   output cbus_req_t        oreq,
   input  cbus_resp_t       oresp,
   output logic             busy,
   output logic [IDX_W-1:0] grant_idx
);

   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_INPUTS - 1);
   localparam int               C_VEC_W    = 1 << IDX_W;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t           r_state;
   logic             r_busy;
   logic [IDX_W-1:0] r_grant_idx;
   logic [IDX_W-1:0] r_prio_ptr;

   logic [C_VEC_W-1:0] w_valid_vec;
   logic               w_found;
   logic [IDX_W-1:0]   w_sel_idx;
   logic               w_release;
   logic [IDX_W-1:0]   w_next_ptr;

   // Valid bits padded to a power of two so any IDX_W-wide index is in range.
   always_comb begin : p_valid_vec
      w_valid_vec = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         w_valid_vec[i] = ireqs[i].valid;
      end
   end

   // Cyclic search starting at the priority pointer. The index wraps by an
   // explicit compare against the last port so non-power-of-two counts work.
   always_comb begin : p_select
      logic [IDX_W-1:0] v_idx;
      v_idx     = r_prio_ptr;
      w_found   = 1'b0;
      w_sel_idx = r_prio_ptr;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         if (!w_found && w_valid_vec[v_idx]) begin
            w_found   = 1'b1;
            w_sel_idx = v_idx;
         end
         v_idx = (v_idx == C_LAST_IDX) ? '0 : v_idx + 1'b1;
      end
   end

   assign w_release  = oresp.ready && oresp.last;
   assign w_next_ptr = (r_grant_idx == C_LAST_IDX) ? '0 : r_grant_idx + 1'b1;

   always_ff @(posedge clk) begin : p_fsm
      if (!resetn) begin
         r_state     <= ST_IDLE;
         r_busy      <= 1'b0;
         r_grant_idx <= '0;
         r_prio_ptr  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_state     <= ST_BUSY;
                  r_busy      <= 1'b1;
                  r_grant_idx <= w_sel_idx;
               end
            end
            ST_BUSY: begin
               // Ownership ends only on the final response beat; a dropped
               // valid from the owner does not free the bus.
               if (w_release) begin
                  r_state    <= ST_IDLE;
                  r_busy     <= 1'b0;
                  r_prio_ptr <= w_next_ptr;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Request/response routing is a combinational pass-through for the owner;
   // everything else is driven to zero.
   always_comb begin : p_route
      oreq = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         iresps[i] = '0;
         if (r_state == ST_BUSY && r_grant_idx == IDX_W'(i)) begin
            oreq      = ireqs[i];
            iresps[i] = oresp;
         end
      end
   end

   assign busy      = r_busy;
   assign grant_idx = r_grant_idx;

endmodule

`default_nettype wire

// File: tb/tb_cbus_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module   : tb_cbus_rr_arbiter
// Purpose  : Self-checking bench for cbus_rr_arbiter (2-port and 3-port
//            instances). Expected grants and response beats are queued when
//            stimulus is driven and compared when the DUT produces them.
// Revision : 1.0 - initial release
//==============================================================================
module tb_cbus_rr_arbiter;
   import cbus_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       resetn;
   cbus_req_t  ireqs  [2];
   cbus_resp_t iresps [2];
   cbus_req_t  oreq;
   cbus_resp_t oresp;
   logic       busy;
   logic [0:0] grant_idx;

   cbus_req_t  ireqs3  [3];
   cbus_resp_t iresps3 [3];
   cbus_req_t  oreq3;
   cbus_resp_t oresp3;
   logic       busy3;
   logic [1:0] grant3;

   cbus_rr_arbiter #(.NUM_INPUTS(2)) dut (
      .clk      (clk),
      .resetn   (resetn),
      .ireqs    (ireqs),
      .iresps   (iresps),
      .oreq     (oreq),
      .oresp    (oresp),
      .busy     (busy),
      .grant_idx(grant_idx)
   );

   cbus_rr_arbiter #(.NUM_INPUTS(3)) dut3 (
      .clk      (clk),
      .resetn   (resetn),
      .ireqs    (ireqs3),
      .iresps   (iresps3),
      .oreq     (oreq3),
      .oresp    (oresp3),
      .busy     (busy3),
      .grant_idx(grant3)
   );

   typedef struct {
      int          port;
      logic        last;
      logic [31:0] data;
   } beat_t;

   beat_t exp_q  [$];
   int    gexp_q [$];
   int    n_checks = 0;
   int    n_errors = 0;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic cbus_req_t mk_req(input logic v, input logic we, input logic [3:0] len,
                                        input logic [31:0] addr);
      cbus_req_t r;
      r          = '0;
      r.valid    = v;
      r.is_write = we;
      r.size     = 2'd2;
      r.addr     = addr;
      r.strobe   = we ? 4'hF : 4'h0;
      r.data     = we ? ~addr : 32'h0;
      r.len      = len;
      return r;
   endfunction

   // Drive n response beats for the owner 'port'; optionally raise a port-0
   // request at beat raise_at. Entered and left at posedge+1.
   task automatic beats(input int port, input int n, input bit end_last, input int raise_at);
      for (int k = 0; k < n; k++) begin
         beat_t b;
         b.port = port;
         b.last = end_last && (k == n - 1);
         b.data = {8'hA5, 8'(port), 16'(k)};
         oresp.ready = 1'b1;
         oresp.last  = b.last;
         oresp.data  = b.data;
         exp_q.push_back(b);
         if (k == raise_at) begin
            ireqs[0] = mk_req(1'b1, 1'b0, 4'd0, 32'h0000_0400);
            gexp_q.push_back(0);
         end
         @(negedge clk);
         chk("oreq_pass", oreq, ireqs[port]);
         tick();
      end
      oresp = '0;
   endtask

   // Scoreboard: response beats checked on every port, grants on busy rise.
   logic prev_busy = 1'b0;
   always @(negedge clk) begin : p_monitor
      beat_t      b;
      cbus_resp_t e;
      if (oresp.ready) begin
         if (exp_q.size() == 0) begin
            chk("sb_underflow", 1, 0);
         end else begin
            b = exp_q.pop_front();
            for (int i = 0; i < 2; i++) begin
               e = '0;
               if (i == b.port) begin
                  e.ready = 1'b1;
                  e.last  = b.last;
                  e.data  = b.data;
               end
               chk($sformatf("iresp[%0d]", i), iresps[i], e);
            end
         end
      end
      if (busy && !prev_busy) begin
         if (gexp_q.size() == 0) chk("grant_underflow", 1, 0);
         else                    chk("grant", grant_idx, gexp_q.pop_front());
      end
      prev_busy <= busy;
   end

   initial begin
      resetn = 1'b0;
      oresp  = '0;
      oresp3 = '0;
      for (int i = 0; i < 2; i++) ireqs[i]  = '0;
      for (int i = 0; i < 3; i++) ireqs3[i] = '0;
      repeat (3) tick();

      // Reset state
      chk("rst_busy",   busy, 0);
      chk("rst_grant",  grant_idx, 0);
      chk("rst_oreq",   oreq, 0);
      chk("rst_iresp0", iresps[0], 0);
      chk("rst_iresp1", iresps[1], 0);
      chk("rst_ptr",    dut.r_prio_ptr, 0);
      resetn = 1'b1;
      tick();

      // Reset asserted mid-burst while port 1 owns the bus
      ireqs[1] = mk_req(1'b1, 1'b0, 4'd7, 32'h0000_1000);
      gexp_q.push_back(1);
      tick();
      chk("a_busy", busy, 1);
      beats(1, 2, 1'b0, -1);
      chk("a_busy_mid", busy, 1);
      resetn = 1'b0;
      tick();
      chk("a_rst_busy",   busy, 0);
      chk("a_rst_grant",  grant_idx, 0);
      chk("a_rst_ptr",    dut.r_prio_ptr, 0);
      chk("a_rst_oreq",   oreq, 0);
      chk("a_rst_iresp0", iresps[0], 0);
      chk("a_rst_iresp1", iresps[1], 0);
      ireqs[1] = '0;
      resetn   = 1'b1;
      tick();

      // Single requester, 4-beat read on port 1
      ireqs[1] = mk_req(1'b1, 1'b0, 4'd3, 32'h0000_2000);
      gexp_q.push_back(1);
      #1;
      chk("b_busy_pre", busy, 0);
      tick();
      chk("b_busy", busy, 1);
      beats(1, 4, 1'b1, -1);
      ireqs[1] = '0;
      chk("b_idle", busy, 0);
      chk("b_ptr",  dut.r_prio_ptr, 0);

      // Simultaneous requests: grant order 0,1,0
      ireqs[0] = mk_req(1'b1, 1'b0, 4'd1, 32'h0000_3000);
      ireqs[1] = mk_req(1'b1, 1'b1, 4'd1, 32'h0000_3100);
      gexp_q.push_back(0);
      gexp_q.push_back(1);
      gexp_q.push_back(0);
      tick();
      chk("c_busy0", busy, 1);
      beats(0, 2, 1'b1, -1);
      #1;
      chk("c_gap_busy",  busy, 0);
      chk("c_gap_valid", oreq.valid, 0);
      tick();
      chk("c_busy1", busy, 1);
      beats(1, 2, 1'b1, -1);
      ireqs[1] = '0;
      #1;
      chk("c_gap2_busy", busy, 0);
      tick();
      chk("c_busy2", busy, 1);
      beats(0, 2, 1'b1, -1);
      ireqs[0] = '0;
      chk("c_ptr", dut.r_prio_ptr, 1);

      // No preemption: port 0 requests during port 1's 8-beat write
      ireqs[1] = mk_req(1'b1, 1'b1, 4'd7, 32'h0000_4000);
      gexp_q.push_back(1);
      tick();
      chk("d_busy", busy, 1);
      beats(1, 8, 1'b1, 2);
      ireqs[1] = '0;
      chk("d_gap_busy", busy, 0);
      tick();
      chk("d_busy0", busy, 1);
      beats(0, 1, 1'b1, -1);
      ireqs[0] = '0;

      // Owner drops valid mid-burst
      ireqs[1] = mk_req(1'b1, 1'b0, 4'd3, 32'h0000_5000);
      gexp_q.push_back(1);
      tick();
      beats(1, 1, 1'b0, -1);
      ireqs[1].valid = 1'b0;
      repeat (2) begin
         #1;
         chk("e_busy",  busy, 1);
         chk("e_valid", oreq.valid, 0);
         chk("e_grant", grant_idx, 1);
         tick();
      end
      beats(1, 1, 1'b1, -1);
      ireqs[1] = '0;
      chk("e_idle", busy, 0);
      chk("e_ptr",  dut.r_prio_ptr, 0);

      // Three ports always requesting, single-beat transactions
      for (int i = 0; i < 3; i++) ireqs3[i] = mk_req(1'b1, 1'b0, 4'd0, 32'h0000_6000 + 32'(i * 16));
      for (int t = 0; t < 6; t++) begin
         int         e;
         cbus_resp_t r;
         e = t % 3;
         tick();
         chk("f_busy",  busy3, 1);
         chk("f_grant", grant3, e);
         oresp3.ready = 1'b1;
         oresp3.last  = 1'b1;
         oresp3.data  = 32'hC0DE_0000 + 32'(t);
         r = oresp3;
         @(negedge clk);
         chk("f_oreq",  oreq3, ireqs3[e]);
         chk("f_resp",  iresps3[e], r);
         chk("f_other", iresps3[(e + 1) % 3], 0);
         tick();
         oresp3 = '0;
         chk("f_idle", busy3, 0);
         chk("f_ptr",  dut3.r_prio_ptr, (e == 2) ? 0 : e + 1);
      end
      for (int i = 0; i < 3; i++) ireqs3[i] = '0;
      tick();

      chk("sb_empty",    exp_q.size(), 0);
      chk("grant_empty", gexp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
